// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter and the DMA requesters that use it.
package sram_arbiter_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  localparam logic [1:0] REQ_WB    = 2'd0;
  localparam logic [1:0] REQ_MMUL  = 2'd1;
  localparam logic [1:0] REQ_MCONV = 2'd2;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Only 01 and 11 request service; 10 is treated like 00.
  function automatic logic op_active(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] r;
    case (idx)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: scans upward from last+1 with wrap.
module rr_pick3
  import sram_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [2:0] elig;
  logic [1:0] idx;

  assign elig = req & ~mask;

  // First eligible requester after the previous winner wins.
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    idx    = rr_next(last);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && elig[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates three requesters onto a single-port RAM256 with 1-cycle read.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | pick a round-robin winner and latch its request
// ST_ISSUE   | drive the RAM strobe, address, byte enables and data
// ST_CAPTURE | RAM output valid; register it into rdata for reads
// ST_DONE    | one-cycle done pulse to the winner, rdata valid
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            req_op,
  input  logic [3*AWIDTH-1:0]   req_addr,
  input  logic [95:0]           req_wdata,
  input  logic [11:0]           req_sel,
  output logic [2:0]            done,
  output logic [31:0]           rdata,
  output logic [2:0]            grant,
  output logic                  busy,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [AWIDTH-1:0]     sram_addr,
  output logic [31:0]           sram_data_i,
  input  logic [31:0]           sram_data_o
);

  logic [1:0]        op_a    [NUM_REQ];
  logic [AWIDTH-1:0] addr_a  [NUM_REQ];
  logic [31:0]       wdata_a [NUM_REQ];
  logic [3:0]        sel_a   [NUM_REQ];
  logic [2:0]        req_vec;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g]    = req_op[2*g +: 2];
    assign addr_a[g]  = req_addr[g*AWIDTH +: AWIDTH];
    assign wdata_a[g] = req_wdata[32*g +: 32];
    assign sel_a[g]   = req_sel[4*g +: 4];
    assign req_vec[g] = op_active(op_a[g]);
  end

  state_e            state_q, state_d;
  logic [1:0]        win_q, win_d;
  logic [1:0]        last_q, last_d;
  logic [2:0]        mask_q, mask_d;
  logic [1:0]        op_q, op_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]        pick_win;
  logic              pick_valid;

  rr_pick3 u_pick (
    .req    (req_vec),
    .mask   (mask_q),
    .last   (last_q),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  // State and latched-request registers; last_q resets to 2 so requester 0 goes first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      win_q   <= 2'd0;
      last_q  <= REQ_MCONV;
      mask_q  <= 3'b000;
      op_q    <= MEM_OP_NONE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      sel_q   <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state; the mask only lives for the IDLE cycle right after DONE.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    mask_d  = 3'b000;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          win_d   = pick_win;
          last_d  = pick_win;
          op_d    = op_a[pick_win];
          addr_d  = addr_a[pick_win];
          wdata_d = wdata_a[pick_win];
          sel_d   = sel_a[pick_win];
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_DONE;
        if (op_q == MEM_OP_READ) rdata_d = sram_data_o;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mask_d  = onehot3(win_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; RAM pins are quiet outside ISSUE.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    grant       = busy ? onehot3(win_q) : 3'b000;
    done        = (state_q == ST_DONE) ? onehot3(win_q) : 3'b000;
    sram_en     = (state_q == ST_ISSUE);
    sram_we     = (sram_en && op_q == MEM_OP_WRITE) ? sel_q : 4'h0;
    sram_addr   = sram_en ? addr_q : '0;
    sram_data_i = sram_en ? wdata_q : 32'h0;
    rdata       = rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural RAM256 model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    op_a   [3] = '{default: 2'b00};
  logic [AW-1:0] addr_a [3] = '{default: '0};
  logic [31:0]   wd_a   [3] = '{default: 32'h0};
  logic [3:0]    sel_a  [3] = '{default: 4'h0};

  logic [5:0]      req_op;
  logic [3*AW-1:0] req_addr;
  logic [95:0]     req_wdata;
  logic [11:0]     req_sel;
  logic [2:0]      done, grant;
  logic [31:0]     rdata, sram_data_i, sram_data_o;
  logic            busy, sram_en;
  logic [3:0]      sram_we;
  logic [AW-1:0]   sram_addr;

  assign req_op    = {op_a[2], op_a[1], op_a[0]};
  assign req_addr  = {addr_a[2], addr_a[1], addr_a[0]};
  assign req_wdata = {wd_a[2], wd_a[1], wd_a[0]};
  assign req_sel   = {sel_a[2], sel_a[1], sel_a[0]};

  sram_arbiter #(.AWIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_sel     (req_sel),
    .done        (done),
    .rdata       (rdata),
    .grant       (grant),
    .busy        (busy),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_data_i (sram_data_i),
    .sram_data_o (sram_data_o)
  );

  // RAM256 model: byte-write, 1-cycle synchronous read.
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] ram_q = 32'h0;
  assign sram_data_o = ram_q;
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_data_i[8*b +: 8];
      ram_q <= mem[sram_addr];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [256] = '{default: 32'h0};
  logic [31:0] last_rd = 32'h0;
  int          cyc = 0;
  int          done_cyc [3] = '{default: 0};
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Each done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (done != 3'b000) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", {61'h0, done}, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("done_idx", {61'h0, done}, {61'h0, 3'b001 << mon_e.idx});
        check_eq("grant_at_done", {61'h0, grant}, {61'h0, 3'b001 << mon_e.idx});
        check_eq("rdata", {32'h0, rdata}, {32'h0, mon_e.rdata});
        done_cyc[mon_e.idx] = cyc;
      end
    end
  end

  // Predicts a transaction in service order.
  task automatic expect_txn(input int idx, input logic [1:0] op, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel);
    exp_t e;
    if (op == MEM_OP_WRITE) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) shadow[addr][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      last_rd = shadow[addr];
    end
    e.idx   = idx;
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int idx, input int lat, input logic [1:0] op,
                           input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (lat != 0 && n == 2) begin
        check_eq("issue_en", {63'h0, sram_en}, 64'h1);
        check_eq("issue_addr", {56'h0, sram_addr}, {56'h0, addr});
        check_eq("issue_we", {60'h0, sram_we}, {60'h0, (op == MEM_OP_WRITE) ? sel : 4'h0});
        if (op == MEM_OP_WRITE) check_eq("issue_wdata", {32'h0, sram_data_i}, {32'h0, wdata});
      end
      if (done[idx]) got = 1;
    end
    check_eq("done_seen", {63'h0, got}, 64'h1);
    if (lat != 0) check_eq("latency", n, 4);
    // keep the op up through the following IDLE cycle
    @(posedge clk);
    @(posedge clk);
    #1 op_a[idx] = MEM_OP_NONE;
  endtask

  task automatic drive_req(input int idx, input logic [1:0] op, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel, input int lat);
    @(posedge clk);
    #1;
    op_a[idx]   = op;
    addr_a[idx] = addr;
    wd_a[idx]   = wdata;
    sel_a[idx]  = sel;
    wait_done(idx, lat, op, addr, wdata, sel);
  endtask

  task automatic req(input int idx, input logic [1:0] op, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [3:0] sel);
    expect_txn(idx, op, addr, wdata, sel);
    drive_req(idx, op, addr, wdata, sel, 1);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    @(negedge clk);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_grant", {61'h0, grant}, 64'h0);
    check_eq("rst_done", {61'h0, done}, 64'h0);
    check_eq("rst_en", {63'h0, sram_en}, 64'h0);
    check_eq("rst_rdata", {32'h0, rdata}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // write then read
    req(0, MEM_OP_WRITE, 8'h10, 32'hDEADBEEF, 4'hF);
    req(0, MEM_OP_READ,  8'h10, 32'h0, 4'h0);

    // byte mask
    req(0, MEM_OP_WRITE, 8'h20, 32'h00000000, 4'hF);
    req(0, MEM_OP_WRITE, 8'h20, 32'h11223344, 4'b0101);
    req(0, MEM_OP_READ,  8'h20, 32'h0, 4'h0);

    // preload for contention
    req(1, MEM_OP_WRITE, 8'h31, 32'h11110031, 4'hF);
    req(2, MEM_OP_WRITE, 8'h32, 32'h22220032, 4'hF);

    // contention: last grant is 2, so order 0,1,2
    expect_txn(0, MEM_OP_READ, 8'h10, 32'h0, 4'h0);
    expect_txn(1, MEM_OP_READ, 8'h31, 32'h0, 4'h0);
    expect_txn(2, MEM_OP_READ, 8'h32, 32'h0, 4'h0);
    fork
      drive_req(0, MEM_OP_READ, 8'h10, 32'h0, 4'h0, 0);
      drive_req(1, MEM_OP_READ, 8'h31, 32'h0, 4'h0, 0);
      drive_req(2, MEM_OP_READ, 8'h32, 32'h0, 4'h0, 0);
    join
    check_eq("spacing_0_1", done_cyc[1] - done_cyc[0], 4);
    check_eq("spacing_1_2", done_cyc[2] - done_cyc[1], 4);

    // hold-off: 1 keeps its op after done, 2 is served next
    expect_txn(1, MEM_OP_READ, 8'h31, 32'h0, 4'h0);
    expect_txn(2, MEM_OP_READ, 8'h20, 32'h0, 4'h0);
    fork
      drive_req(1, MEM_OP_READ, 8'h31, 32'h0, 4'h0, 0);
      drive_req(2, MEM_OP_READ, 8'h20, 32'h0, 4'h0, 0);
    join

    // round-robin start point: after 1 is served, 2 beats 0
    req(1, MEM_OP_READ, 8'h32, 32'h0, 4'h0);
    expect_txn(2, MEM_OP_READ, 8'h10, 32'h0, 4'h0);
    expect_txn(0, MEM_OP_READ, 8'h31, 32'h0, 4'h0);
    fork
      drive_req(0, MEM_OP_READ, 8'h31, 32'h0, 4'h0, 0);
      drive_req(2, MEM_OP_READ, 8'h10, 32'h0, 4'h0, 0);
    join

    // empty byte mask still completes; rdata untouched by writes
    req(2, MEM_OP_WRITE, 8'h10, 32'hFFFFFFFF, 4'h0);
    req(0, MEM_OP_READ,  8'h10, 32'h0, 4'h0);

    // reset during CAPTURE
    expect_txn(0, MEM_OP_READ, 8'h31, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    op_a[0] = MEM_OP_READ;
    addr_a[0] = 8'h31;
    n = 0;
    while (n < 20 && !sram_en) begin
      @(negedge clk);
      n++;
    end
    check_eq("en_before_reset", {63'h0, sram_en}, 64'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_done", {61'h0, done}, 64'h0);
    check_eq("mid_rst_grant", {61'h0, grant}, 64'h0);
    check_eq("mid_rst_busy", {63'h0, busy}, 64'h0);
    check_eq("mid_rst_en", {63'h0, sram_en}, 64'h0);
    check_eq("mid_rst_we", {60'h0, sram_we}, 64'h0);
    check_eq("mid_rst_addr", {56'h0, sram_addr}, 64'h0);
    check_eq("mid_rst_wdata", {32'h0, sram_data_i}, 64'h0);
    check_eq("mid_rst_rdata", {32'h0, rdata}, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_done(0, 0, MEM_OP_READ, 8'h31, 32'h0, 4'h0);

    // illegal op 10 never starts an access
    @(posedge clk);
    #1 op_a[2] = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("illegal_busy", {63'h0, busy}, 64'h0);
      check_eq("illegal_en", {63'h0, sram_en}, 64'h0);
    end
    op_a[2] = MEM_OP_NONE;

    repeat (4) @(posedge clk);
    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
